// File: rtl/udp_result_parser.sv
// Avalon-ST sink for the 167-word algo result packet: framing check, channel RAM write-out,
// atomic header/recon commit to CSRs. Optional irq output with macro UDP_PARSER_IRQ_EN.
module udp_result_parser #(
  parameter int unsigned HDR_WORDS   = 3,
  parameter int unsigned CH_WORDS    = 160,
  parameter int unsigned RECON_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  output logic        in_ready,
  input  logic        in_valid,
  input  logic [1:0]  in_empty,
  input  logic        in_sop,
  input  logic        in_eop,
  input  logic [2:0]  csr_address,
  input  logic        csr_read,
  output logic [31:0] csr_readdata,
  input  logic        csr_write,
  input  logic [31:0] csr_writedata,
  output logic [7:0]  ch_wr_address,
  output logic [31:0] ch_wr_data,
  output logic        ch_wr_en,
  output logic        frame_done
`ifdef UDP_PARSER_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int unsigned TOTAL  = HDR_WORDS + CH_WORDS + RECON_WORDS;
  localparam int unsigned CW     = $clog2(TOTAL + 1);
  localparam int unsigned LAST   = TOTAL - 1;
  localparam int unsigned CH_END = HDR_WORDS + CH_WORDS;
  localparam int unsigned AW     = 8;
  localparam int unsigned RW     = (RECON_WORDS > 1) ? $clog2(RECON_WORDS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_CH, S_RECON, S_DROP} state_t;

  state_t          state, nstate;
  logic [CW-1:0]   word_cnt, ncnt;
  logic            beat_c, err_c, commit_c, ch_we_c, hdr0_we_c, rec_we_c;
  logic            clear_c, irq_clr_c, irq_bit;
  logic [RW-1:0]   rec_idx_c;
  logic [31:0]     hdr_sh0;
  logic [31:0]     rec_sh [RECON_WORDS-1];
  logic [31:0]     frame_cnt, err_cnt, hdr0_q;
  logic [31:0]     recon_q [RECON_WORDS];
  logic [31:0]     rd_mux_c;

  assign beat_c    = in_valid & in_ready;
  assign clear_c   = csr_write && (csr_address == 3'd0) && csr_writedata[1];
  assign irq_clr_c = csr_write && (csr_address == 3'd0) && csr_writedata[2];
  assign rec_idx_c = RW'(word_cnt - CW'(CH_END));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      word_cnt <= '0;
    end else begin
      state    <= nstate;
      word_cnt <= ncnt;
    end
  end

  // Next-state and per-beat strobes; a sop always restarts the packet at index 0
  always_comb begin
    nstate    = state;
    ncnt      = word_cnt;
    err_c     = 1'b0;
    commit_c  = 1'b0;
    ch_we_c   = 1'b0;
    hdr0_we_c = 1'b0;
    rec_we_c  = 1'b0;
    if (beat_c) begin
      if (in_sop && in_eop) begin
        err_c  = 1'b1;
        nstate = S_IDLE;
        ncnt   = '0;
      end else if (in_sop) begin
        err_c     = (state != S_IDLE);
        hdr0_we_c = 1'b1;
        ncnt      = CW'(1);
        nstate    = (HDR_WORDS == 1) ? S_CH : S_HDR;
      end else begin
        unique case (state)
          S_IDLE: err_c = 1'b1;
          S_DROP: begin
            if (in_eop) begin
              nstate = S_IDLE;
              ncnt   = '0;
            end
          end
          default: begin
            if (in_eop && (word_cnt != CW'(LAST))) begin
              err_c  = 1'b1;
              nstate = S_IDLE;
              ncnt   = '0;
            end else begin
              ncnt = word_cnt + CW'(1);
              unique case (state)
                S_HDR: begin
                  if (word_cnt == CW'(HDR_WORDS - 1)) nstate = S_CH;
                end
                S_CH: begin
                  ch_we_c = 1'b1;
                  if (word_cnt == CW'(CH_END - 1)) nstate = S_RECON;
                end
                S_RECON: begin
                  rec_we_c = 1'b1;
                  if (word_cnt == CW'(LAST)) begin
                    ncnt = '0;
                    if (in_eop) begin
                      commit_c = 1'b1;
                      nstate   = S_IDLE;
                    end else begin
                      err_c  = 1'b1;
                      nstate = S_DROP;
                    end
                  end
                end
                default: nstate = S_IDLE;
              endcase
            end
          end
        endcase
      end
    end
  end

  // Beat capture: channel write-out and header/recon shadow registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_wr_en      <= 1'b0;
      ch_wr_address <= '0;
      ch_wr_data    <= '0;
      frame_done    <= 1'b0;
      hdr_sh0       <= '0;
      for (int i = 0; i < int'(RECON_WORDS) - 1; i++) rec_sh[i] <= '0;
    end else begin
      ch_wr_en   <= ch_we_c;
      frame_done <= commit_c;
      if (ch_we_c) begin
        ch_wr_address <= AW'(word_cnt - CW'(HDR_WORDS));
        ch_wr_data    <= in_data;
      end
      if (hdr0_we_c) hdr_sh0 <= in_data;
      if (rec_we_c && (word_cnt != CW'(LAST))) rec_sh[rec_idx_c] <= in_data;
    end
  end

  // CSR registers; the last recon word is committed straight from the final beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready     <= 1'b0;
      frame_cnt    <= '0;
      err_cnt      <= '0;
      hdr0_q       <= '0;
      csr_readdata <= '0;
      for (int i = 0; i < int'(RECON_WORDS); i++) recon_q[i] <= '0;
    end else begin
      if (csr_write && (csr_address == 3'd0)) in_ready <= csr_writedata[0];
      if (clear_c)       frame_cnt <= '0;
      else if (commit_c) frame_cnt <= frame_cnt + 32'd1;
      if (clear_c)       err_cnt <= '0;
      else if (err_c)    err_cnt <= err_cnt + 32'd1;
      if (commit_c) begin
        hdr0_q <= hdr_sh0;
        for (int i = 0; i < int'(RECON_WORDS) - 1; i++) recon_q[i] <= rec_sh[i];
        recon_q[RECON_WORDS-1] <= in_data;
      end
      if (csr_read) csr_readdata <= rd_mux_c;
    end
  end

  always_comb begin
    rd_mux_c = '0;
    unique case (csr_address)
      3'd0:    rd_mux_c = {28'd0, irq_bit, 2'b00, in_ready};
      3'd1:    rd_mux_c = frame_cnt;
      3'd2:    rd_mux_c = err_cnt;
      3'd3:    rd_mux_c = hdr0_q;
      3'd4:    rd_mux_c = recon_q[0];
      3'd5:    rd_mux_c = recon_q[1];
      3'd6:    rd_mux_c = recon_q[2];
      default: rd_mux_c = recon_q[3];
    endcase
  end

`ifdef UDP_PARSER_IRQ_EN
  // Commit has priority over a same-cycle clear so a fresh frame is never lost
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            irq <= 1'b0;
    else if (commit_c)  irq <= 1'b1;
    else if (irq_clr_c) irq <= 1'b0;
  end
  assign irq_bit = irq;

  logic unused_ok;
  assign unused_ok = ^{in_empty, csr_writedata[31:3]};
`else
  assign irq_bit = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{in_empty, csr_writedata[31:3], irq_clr_c};
`endif

endmodule

// File: tb/tb_udp_result_parser.sv
// Directed bench for udp_result_parser: framing errors, commit, counters, stalls, async reset.
module tb_udp_result_parser;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_ready;
  logic        in_valid;
  logic [1:0]  in_empty;
  logic        in_sop;
  logic        in_eop;
  logic [2:0]  csr_address;
  logic        csr_read;
  logic [31:0] csr_readdata;
  logic        csr_write;
  logic [31:0] csr_writedata;
  logic [7:0]  ch_wr_address;
  logic [31:0] ch_wr_data;
  logic        ch_wr_en;
  logic        frame_done;
`ifdef UDP_PARSER_IRQ_EN
  logic        irq;
`endif

  always #5 clk = ~clk;

  udp_result_parser dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_ready(in_ready), .in_valid(in_valid), .in_empty(in_empty),
    .in_sop(in_sop), .in_eop(in_eop),
    .csr_address(csr_address), .csr_read(csr_read), .csr_readdata(csr_readdata),
    .csr_write(csr_write), .csr_writedata(csr_writedata),
    .ch_wr_address(ch_wr_address), .ch_wr_data(ch_wr_data), .ch_wr_en(ch_wr_en),
    .frame_done(frame_done)
`ifdef UDP_PARSER_IRQ_EN
    , .irq(irq)
`endif
  );

  int vectors = 0;
  int miscompares = 0;
  int wr_cnt = 0;
  int fd_cnt = 0;
  logic [31:0] ram [256];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // RAM model and frame_done counter, sampled mid-cycle
  always @(negedge clk) begin
    if (ch_wr_en) begin
      ram[ch_wr_address] = ch_wr_data;
      wr_cnt++;
    end
    if (frame_done) fd_cnt++;
  end

  // All driver tasks start and end at a falling edge
  task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
    csr_address = a; csr_writedata = d; csr_write = 1'b1;
    @(negedge clk);
    csr_write = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
    csr_address = a; csr_read = 1'b1;
    @(negedge clk);
    csr_read = 1'b0;
    chk(tag, csr_readdata, exp);
  endtask

  task automatic send_beat(input logic [31:0] d, input logic sop, input logic eop);
    int n;
    in_data = d; in_sop = sop; in_eop = eop; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk("ready_timeout", 32'd1, 32'd0);
    @(negedge clk);
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  task automatic send_pkt(input logic [31:0] base, input int nbeats, input int eop_idx,
                          input bit gaps, input int toggle_at, input bit clr_last);
    for (int i = 0; i < nbeats; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      if (i == toggle_at) begin
        csr_wr(3'd0, 32'd0);
        in_data = base + 32'(i); in_sop = (i == 0); in_eop = (i == eop_idx); in_valid = 1'b1;
        repeat (4) @(negedge clk);
        csr_wr(3'd0, 32'd1);
      end
      if (clr_last && i == nbeats - 1) begin
        csr_address = 3'd0; csr_writedata = 32'd5; csr_write = 1'b1;
      end
      send_beat(base + 32'(i), i == 0, i == eop_idx);
      csr_write = 1'b0;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_ram(input string tag, input logic [31:0] base);
    int bad;
    bad = 0;
    for (int a = 0; a < 160; a++) if (ram[a] !== base + 32'(a + 3)) bad++;
    chk(tag, 32'(bad), 32'd0);
  endtask

  task automatic chk_recon(input string tag, input logic [31:0] base);
    rd_chk({tag, "_r0"}, 3'd4, base + 32'd163);
    rd_chk({tag, "_r1"}, 3'd5, base + 32'd164);
    rd_chk({tag, "_r2"}, 3'd6, base + 32'd165);
    rd_chk({tag, "_r3"}, 3'd7, base + 32'd166);
  endtask

  initial begin
    int w0;
    rst = 1'b1; in_data = '0; in_valid = 1'b0; in_empty = 2'b00; in_sop = 1'b0; in_eop = 1'b0;
    csr_address = '0; csr_read = 1'b0; csr_write = 1'b0; csr_writedata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_ch_wr_en", 32'(ch_wr_en), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_readdata", csr_readdata, 32'd0);
    rd_chk("rst_frame_cnt", 3'd1, 32'd0);
    rd_chk("rst_recon0", 3'd4, 32'd0);

    csr_wr(3'd0, 32'd1);
    rd_chk("ctrl_enable", 3'd0, 32'd1);

    // Good packet, data = index
    w0 = wr_cnt;
    send_pkt(32'd0, 167, 166, 1'b0, -1, 1'b0);
    chk_ram("good_ram", 32'd0);
    chk("good_wr_cnt", 32'(wr_cnt - w0), 32'd160);
    chk("good_fd", 32'(fd_cnt), 32'd1);
    chk_recon("good", 32'd0);
    rd_chk("good_hdr0", 3'd3, 32'd0);
    rd_chk("good_frames", 3'd1, 32'd1);
    rd_chk("good_errs", 3'd2, 32'd0);

    // Early eop at beat 100
    send_pkt(32'd1000, 101, 100, 1'b0, -1, 1'b0);
    rd_chk("early_errs", 3'd2, 32'd1);
    rd_chk("early_frames", 3'd1, 32'd1);
    chk_recon("early", 32'd0);
    chk("early_fd", 32'(fd_cnt), 32'd1);
    send_pkt(32'd2000, 167, 166, 1'b0, -1, 1'b0);
    rd_chk("after_early_frames", 3'd1, 32'd2);
    chk_recon("after_early", 32'd2000);
    rd_chk("after_early_hdr0", 3'd3, 32'd2000);
    chk_ram("after_early_ram", 32'd2000);

    // Missing eop at 166, eop at 170
    w0 = wr_cnt;
    send_pkt(32'd3000, 171, 170, 1'b0, -1, 1'b0);
    chk("late_wr_cnt", 32'(wr_cnt - w0), 32'd160);
    rd_chk("late_errs", 3'd2, 32'd2);
    rd_chk("late_frames", 3'd1, 32'd2);
    rd_chk("late_recon0", 3'd4, 32'd2163);
    send_pkt(32'd3500, 167, 166, 1'b0, -1, 1'b0);
    rd_chk("after_late_frames", 3'd1, 32'd3);
    rd_chk("after_late_recon3", 3'd7, 32'd3666);

    // Stray beat in IDLE, then a sop+eop beat
    send_beat(32'hdead, 1'b0, 1'b0);
    rd_chk("idle_nosop_errs", 3'd2, 32'd3);
    send_beat(32'hbeef, 1'b1, 1'b1);
    rd_chk("sop_eop_errs", 3'd2, 32'd4);

    // Clear counters, keep enable
    csr_wr(3'd0, 32'd3);
    rd_chk("clr_frames", 3'd1, 32'd0);
    rd_chk("clr_errs", 3'd2, 32'd0);
    rd_chk("clr_ctrl", 3'd0, 32'd1);

    // sop at beat 50 restarts the packet
    send_pkt(32'd4000, 50, -1, 1'b0, -1, 1'b0);
    send_pkt(32'd5000, 167, 166, 1'b0, -1, 1'b0);
    rd_chk("resop_errs", 3'd2, 32'd1);
    rd_chk("resop_frames", 3'd1, 32'd1);
    chk_recon("resop", 32'd5000);
    rd_chk("resop_hdr0", 3'd3, 32'd5000);
    chk_ram("resop_ram", 32'd5000);

    // Valid gaps plus enable toggled mid-packet
    send_pkt(32'd6000, 167, 166, 1'b1, 80, 1'b0);
    rd_chk("gaps_errs", 3'd2, 32'd1);
    rd_chk("gaps_frames", 3'd1, 32'd2);
    chk_recon("gaps", 32'd6000);
    chk_ram("gaps_ram", 32'd6000);
    chk("gaps_fd", 32'(fd_cnt), 32'd5);

    // Async reset mid-packet
    send_pkt(32'd7000, 60, -1, 1'b0, -1, 1'b0);
    #2 rst = 1'b1;
    #1 chk("arst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rd_chk("arst_frames", 3'd1, 32'd0);
    rd_chk("arst_recon0", 3'd4, 32'd0);
    csr_wr(3'd0, 32'd1);
    send_pkt(32'd8000, 167, 166, 1'b0, -1, 1'b0);
    rd_chk("arst_good_frames", 3'd1, 32'd1);
    rd_chk("arst_good_errs", 3'd2, 32'd0);
    chk_recon("arst_good", 32'd8000);
    chk("arst_fd", 32'(fd_cnt), 32'd6);

`ifdef UDP_PARSER_IRQ_EN
    chk("irq_set", 32'(irq), 32'd1);
    rd_chk("irq_ctrl_set", 3'd0, 32'd9);
    send_pkt(32'd9000, 167, 166, 1'b0, -1, 1'b1);
    chk("irq_clr_vs_commit", 32'(irq), 32'd1);
    csr_wr(3'd0, 32'd5);
    @(negedge clk);
    chk("irq_cleared", 32'(irq), 32'd0);
    rd_chk("irq_ctrl_clr", 3'd0, 32'd1);
`else
    rd_chk("ctrl_no_irq", 3'd0, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
